// File: rtl/guarded_release_pkg.sv
// Shared types and helpers for the guarded release array.
package guarded_release_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic int sel_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/guarded_release_array_phase_tracker.sv
// Phase counter with a trailing shadow counter; flags any break of prev == cnt-1.
module phase_tracker #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] prev,
    output logic             viol
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            prev <= '1;
        end else if (!freeze) begin
            cnt  <= cnt + CNT_W'(1);
            prev <= prev + CNT_W'(1);
        end
    end

    assign viol = (prev != (cnt - CNT_W'(1)));

endmodule

// File: rtl/guarded_release_array.sv
// Per-channel guarded capture of a secret word, released through a valid/ready
// window gated by a self-checking phase counter pair.
module guarded_release_array
    import guarded_release_pkg::*;
#(
    parameter  int DATA_W        = 32,
    parameter  int NUM_CH        = 4,
    parameter  int CNT_W         = 2,
    parameter  int CAP_PHASE     = 3,
    parameter  int REL_PHASE     = 3,
    parameter  int CLEAR_ON_MISS = 0,
    localparam int SEL_W         = sel_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cap_en,
    input  logic [SEL_W-1:0]  cap_sel,
    input  logic [DATA_W-1:0] secret,
    input  logic [NUM_CH-1:0] visible,
    output logic [DATA_W-1:0] out1,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [DATA_W-1:0] out2,
    output logic              out2_valid,
    input  logic              out2_ready,
    input  logic              flush,
    output logic              overrun,
    output logic              alarm,
    output logic [CNT_W-1:0]  phase
);

    state_t            state, state_nx;
    logic              run;
    logic              freeze;
    logic [CNT_W-1:0]  cnt, prev;
    logic              viol;

    logic [DATA_W-1:0] guard [NUM_CH];
    logic [NUM_CH-1:0] gvalid;
    logic [NUM_CH-1:0] cap_hit, cons_hit;
    logic              cap_in, rd_in;
    logic              cap_ok, consume;

    assign run    = (state == RUN);
    assign freeze = !(run && enable);

    phase_tracker #(.CNT_W(CNT_W)) u_phase (
        .clk    (clk),
        .rst_n  (rst_n),
        .freeze (freeze),
        .cnt    (cnt),
        .prev   (prev),
        .viol   (viol)
    );

    // Range checks collapse to constants when NUM_CH fills the select space.
    if (NUM_CH == (1 << SEL_W)) begin : g_full
        assign cap_in = 1'b1;
        assign rd_in  = 1'b1;
    end else begin : g_part
        assign cap_in = (cap_sel < SEL_W'(NUM_CH));
        assign rd_in  = (rd_sel < SEL_W'(NUM_CH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == RUN && viol) state_nx = LOCKED;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)              alarm <= 1'b0;
        else if (run && viol)    alarm <= 1'b1;
    end

    assign cap_ok     = run && cap_en && cap_in && (cnt == CNT_W'(CAP_PHASE));
    assign out2_valid = run && rd_in && (prev == CNT_W'(REL_PHASE)) && gvalid[rd_sel];
    assign out2       = out2_valid ? guard[rd_sel] : '0;
    assign consume    = out2_valid && out2_ready;
    assign out1       = (run && enable && cap_en && visible[cap_sel]) ? secret : '0;
    assign phase      = cnt;

    always_comb begin
        cap_hit  = '0;
        cons_hit = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cap_hit[i]  = cap_ok  && (cap_sel == SEL_W'(i));
            cons_hit[i] = consume && (rd_sel == SEL_W'(i));
        end
    end

    // Priority per channel: flush, then capture, then consume, then miss-clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) guard[i] <= '0;
            gvalid  <= '0;
            overrun <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (flush) begin
                    guard[i]  <= '0;
                    gvalid[i] <= 1'b0;
                end else if (cap_hit[i]) begin
                    guard[i]  <= secret;
                    gvalid[i] <= 1'b1;
                end else if (cons_hit[i] || (CLEAR_ON_MISS != 0 && !cap_ok)) begin
                    guard[i]  <= '0;
                    gvalid[i] <= 1'b0;
                end
            end
            if (!flush && |(cap_hit & gvalid & ~cons_hit)) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_guarded_release_array.sv
// Directed scoreboard bench for guarded_release_array (default and clear-on-miss builds).
module tb_guarded_release_array;

    localparam int SW = 2;

    localparam int S_OUT1   = 0;
    localparam int S_OUT2   = 1;
    localparam int S_VALID  = 2;
    localparam int S_OVR    = 3;
    localparam int S_ALARM  = 4;
    localparam int S_PHASE  = 5;
    localparam int S_CVALID = 6;
    localparam int S_COUT2  = 7;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n, enable, cap_en, out2_ready, flush;
    logic [SW-1:0] cap_sel, rd_sel;
    logic [31:0]   secret;
    logic [3:0]    visible;

    logic [31:0]   out1, out2, c_out1, c_out2;
    logic          out2_valid, overrun, alarm, c_out2_valid, c_overrun, c_alarm;
    logic [1:0]    phase, c_phase;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    guarded_release_array dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cap_en(cap_en), .cap_sel(cap_sel),
        .secret(secret), .visible(visible), .out1(out1), .rd_sel(rd_sel), .out2(out2),
        .out2_valid(out2_valid), .out2_ready(out2_ready), .flush(flush),
        .overrun(overrun), .alarm(alarm), .phase(phase)
    );

    guarded_release_array #(.CLEAR_ON_MISS(1)) dut_com (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cap_en(cap_en), .cap_sel(cap_sel),
        .secret(secret), .visible(visible), .out1(c_out1), .rd_sel(rd_sel), .out2(c_out2),
        .out2_valid(c_out2_valid), .out2_ready(out2_ready), .flush(flush),
        .overrun(c_overrun), .alarm(c_alarm), .phase(c_phase)
    );

    function automatic logic [31:0] obs(input int sig);
        case (sig)
            S_OUT1:   return out1;
            S_OUT2:   return out2;
            S_VALID:  return {31'b0, out2_valid};
            S_OVR:    return {31'b0, overrun};
            S_ALARM:  return {31'b0, alarm};
            S_PHASE:  return {30'b0, phase};
            S_CVALID: return {31'b0, c_out2_valid};
            S_COUT2:  return c_out2;
            default:  return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] o;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sig);
            total++;
            assert (o === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; cap_en = 1'b0; out2_ready = 1'b0; flush = 1'b0;
        cap_sel = '0; rd_sel = '0; secret = '0; visible = '0;
        step();
        step();
        expect_val("rst_phase", S_PHASE, 0);
        expect_val("rst_valid", S_VALID, 0);
        expect_val("rst_ovr",   S_OVR,   0);
        expect_val("rst_alarm", S_ALARM, 0);
        expect_val("rst_out1",  S_OUT1,  0);
        check_all();
        rst_n = 1'b1;

        // basic capture and release
        enable = 1'b1;
        repeat (3) step();
        expect_val("cnt_at_cap", S_PHASE, 3);
        check_all();
        cap_en = 1'b1; cap_sel = 2; secret = 32'hDEADBEEF; visible = 4'b0000;
        expect_val("out1_masked", S_OUT1, 0);
        check_all();
        step();
        enable = 1'b0; cap_en = 1'b0; rd_sel = 2;
        expect_val("rel_valid", S_VALID, 1);
        expect_val("rel_data",  S_OUT2,  32'hDEADBEEF);
        expect_val("rel_phase", S_PHASE, 0);
        check_all();
        out2_ready = 1'b1;
        step();
        out2_ready = 1'b0;
        expect_val("consumed_valid", S_VALID, 0);
        expect_val("consumed_data",  S_OUT2,  0);
        check_all();

        // direct path
        enable = 1'b1; cap_en = 1'b1; cap_sel = 3; secret = 32'h5A5A5A5A; visible = 4'b1000;
        expect_val("direct_vis", S_OUT1, 32'h5A5A5A5A);
        check_all();
        visible = 4'b0111;
        expect_val("direct_hidden", S_OUT1, 0);
        check_all();
        enable = 1'b0; cap_en = 1'b0; visible = 4'b0000;

        // overrun
        enable = 1'b1;
        repeat (3) step();
        cap_en = 1'b1; cap_sel = 1; secret = 32'h11;
        step();
        cap_en = 1'b0; rd_sel = 0;
        expect_val("ovr_first", S_OVR, 0);
        check_all();
        repeat (3) step();
        cap_en = 1'b1; cap_sel = 1; secret = 32'h22;
        step();
        cap_en = 1'b0; enable = 1'b0; rd_sel = 1;
        expect_val("ovr_set",   S_OVR,   1);
        expect_val("ovr_valid", S_VALID, 1);
        expect_val("ovr_data",  S_OUT2,  32'h22);
        check_all();
        out2_ready = 1'b1;
        step();
        out2_ready = 1'b0;
        expect_val("ovr_consumed", S_VALID, 0);
        expect_val("ovr_sticky",   S_OVR,   1);
        check_all();

        // flush beats capture
        enable = 1'b1;
        repeat (3) step();
        cap_en = 1'b1; cap_sel = 0; secret = 32'h33; flush = 1'b1;
        step();
        cap_en = 1'b0; flush = 1'b0; enable = 1'b0; rd_sel = 0;
        expect_val("flush_valid", S_VALID, 0);
        expect_val("flush_data",  S_OUT2,  0);
        expect_val("flush_phase", S_PHASE, 0);
        check_all();

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        expect_val("rst2_ovr",   S_OVR,   0);
        expect_val("rst2_phase", S_PHASE, 0);
        check_all();

        // clear-on-miss versus hold
        enable = 1'b1;
        repeat (3) step();
        enable = 1'b0; cap_en = 1'b1; cap_sel = 2; secret = 32'h77;
        step();
        cap_en = 1'b0;
        expect_val("com_phase",  S_PHASE,  3);
        expect_val("com_valid0", S_CVALID, 0);
        check_all();
        step();
        step();
        enable = 1'b1;
        step();
        enable = 1'b0; rd_sel = 2;
        expect_val("com_valid", S_CVALID, 0);
        expect_val("com_data",  S_COUT2,  0);
        expect_val("hold_valid", S_VALID, 1);
        expect_val("hold_data",  S_OUT2,  32'h77);
        check_all();

        // invariant fault locks the block
        force dut.u_phase.prev = 2'd0;
        expect_val("pre_lock_alarm", S_ALARM, 0);
        check_all();
        step();
        release dut.u_phase.prev;
        secret = 32'hFFFFFFFF; enable = 1'b1; cap_en = 1'b1; cap_sel = 3; visible = 4'b1111; rd_sel = 2;
        expect_val("lock_alarm", S_ALARM, 1);
        expect_val("lock_out1",  S_OUT1,  0);
        expect_val("lock_valid", S_VALID, 0);
        expect_val("lock_out2",  S_OUT2,  0);
        check_all();
        step();
        expect_val("lock_frozen", S_PHASE, 0);
        expect_val("lock_sticky", S_ALARM, 1);
        check_all();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        expect_val("unlock_alarm", S_ALARM, 0);
        expect_val("unlock_valid", S_VALID, 0);
        expect_val("unlock_out1",  S_OUT1,  32'hFFFFFFFF);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
